controller_fsm: RTL
===================

# controller_fsm

Multi-cycle main controller for the RISC-V core: a Moore state machine that sequences the shared ALU, unified memory, instruction register, PC and register file over 3–5 cycles per instruction. It decodes opcode/funct fields from the instruction register and drives every datapath select and write enable. It sits beside the datapath in the multi-cycle top level; the `zero` flag is its only feedback from the datapath.

## Interface
Parameters: none.

Ports:
- `i_clk` — input, 1 — core clock; all state changes on rising edge.
- `i_rst` — input, 1 — asynchronous, active-high reset.
- `i_opcode` — input, 7 — `instr[6:0]` from the instruction register.
- `i_funct3` — input, 3 — `instr[14:12]`.
- `i_funct7b5` — input, 1 — `instr[30]`.
- `i_zero` — input, 1 — ALU result == 0.
- `o_pcWrite` — output, 1 — PC load enable.
- `o_adrSrc` — output, 1 — memory address: 0 = PC, 1 = ALUOut.
- `o_memWrite` — output, 1 — memory write enable.
- `o_irWrite` — output, 1 — instruction register / old-PC load enable.
- `o_regWrite` — output, 1 — register-file write enable.
- `o_resultSrc` — output, 2 — `ty_RESULT_SRC`.
- `o_aluSrcA` — output, 2 — `ty_ALU_SRC_A`.
- `o_aluSrcB` — output, 2 — `ty_ALU_SRC_B`.
- `o_immSrc` — output, 2 — immediate format: I = 00, S = 01, B = 10, J = 11.
- `o_aluControl` — output, 4 — `ty_ALU_OP`.
- `o_illegal` — output, 1 — one-cycle pulse in DECODE for an unsupported instruction.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL. Outputs are functions of the state; defaults are all 0, selects 00, ALU op ADD.
- **FETCH**
  - Outputs: `adrSrc=0`, `irWrite=1`, `aluSrcA=PC`, `aluSrcB=FOUR`, `ADD`, `resultSrc=PCPLUS4`, `pcWrite=1`.
  - Next state: DECODE.
- **DECODE**
  - Outputs: `aluSrcA=OTHER` (old PC), `aluSrcB=IMMEDIATE_EXTENDED`, `ADD` (computes branch/jump target).
  - Next state by opcode: LW/SW → MEMADR; R_TYPE_ALU → EXECUTER; I_TYPE_ALU → EXECUTEI; B_TYPE → BRANCH; JAL → JAL.
  - Any other opcode: `o_illegal=1`, next state FETCH.
- **MEMADR**
  - Outputs: `aluSrcA=REG_READ_DATA_1`, `aluSrcB=IMMEDIATE_EXTENDED`, `ADD`.
  - Next state: MEMREAD for LW, MEMWRITE for SW.
- **MEMREAD**: `adrSrc=1`, `resultSrc=ALU`. Next state MEMWB.
- **MEMWB**: `resultSrc=DATAMEMORY`, `regWrite=1`. Next state FETCH.
- **MEMWRITE**: `adrSrc=1`, `resultSrc=ALU`, `memWrite=1`. Next state FETCH.
- **EXECUTER**: `aluSrcA=REG_READ_DATA_1`, `aluSrcB=REG_READ_DATA_2`, `aluControl={funct7b5,funct3}`. Next state ALUWB.
- **EXECUTEI**: `aluSrcA=REG_READ_DATA_1`, `aluSrcB=IMMEDIATE_EXTENDED`, `aluControl={1'b0,funct3}` (funct7b5 ignored). Next state ALUWB.
- **ALUWB**: `resultSrc=ALU`, `regWrite=1`. Next state FETCH.
- **BRANCH**
  - Outputs: `aluSrcA=REG_READ_DATA_1`, `aluSrcB=REG_READ_DATA_2`, `SUB`, `resultSrc=ALU`.
  - `pcWrite` is the taken condition (see Configuration). Next state FETCH.
- **JAL**: `aluSrcA=OTHER`, `aluSrcB=FOUR`, `ADD`, `resultSrc=ALU`, `pcWrite=1`. Next state ALUWB (writes old PC+4 to rd).
- `o_immSrc` is combinational from `i_opcode` in every state: SW → 01, B_TYPE → 10, JAL → 11, else 00.

## Timing
- Reset is asynchronous: the state goes to FETCH immediately.
- While `i_rst`=1, `o_pcWrite`, `o_irWrite`, `o_regWrite`, `o_memWrite` and `o_illegal` are forced to 0; the other outputs show FETCH values.
- First FETCH is the first rising edge after `i_rst` deasserts.
- Cycles per instruction, FETCH to next FETCH: LW 5, SW 4, R/I-type 4, branch 3, JAL 4, illegal 2.
- `i_opcode`/`i_funct*` are sampled from DECODE onward; they are stable because `irWrite` is asserted only in FETCH.
- Reset mid-instruction abandons the instruction with no partial register or memory write after the reset edge.
- `i_zero` is used only in BRANCH, in the same cycle it is produced.

## Configuration
- Macro `RISCV_BNE_EN`.
- Undefined:
  - Every B_TYPE is BEQ and funct3 is ignored.
  - In BRANCH, `pcWrite = i_zero`.
- Defined:
  - funct3=000 → `pcWrite = i_zero`.
  - funct3=001 → `pcWrite = !i_zero`.
  - Any other funct3 with B_TYPE raises `o_illegal` in DECODE and returns to FETCH.

## Structure
- Package `pa_riscv` holds:
  - `ty_OPERAND` and `ty_ALU_OP`;
  - distinct typedefs `ty_RESULT_SRC`, `ty_ALU_SRC_A`, `ty_ALU_SRC_B`;
  - a new `ty_STATE` enum for the 11 states;
  - `ty_IMM_SRC`.
- Sub-module `alu_decoder`: combinational; maps `{aluOp[1:0], funct3, funct7b5, opcode[5]}` to `o_aluControl`. The FSM drives `aluOp` 00 = ADD, 01 = SUB, 10 = funct.

## Test plan
- `lw x5,8(x2)`, `i_zero=0` → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. Check `adrSrc=1` in MEMREAD, `resultSrc=01` with `regWrite=1` in MEMWB, 5 cycles total.
- `sw` → `memWrite=1` only in its 4th cycle; `regWrite` never asserted; `immSrc=01`.
- `sub` (funct7b5=1, funct3=000) → EXECUTER `aluControl=1000`. `addi` with `instr[30]=1` → EXECUTEI `aluControl=0000`.
- BEQ with `i_zero=1` → `pcWrite=1` in cycle 3; with `i_zero=0` → `pcWrite=0`. With `RISCV_BNE_EN`: BNE with `i_zero=0` → `pcWrite=1`; funct3=100 → `o_illegal` pulse.
- Opcode `0110111` → `o_illegal=1` for one cycle in DECODE, then FETCH.
- Assert `i_rst` during MEMWRITE → `memWrite` drops to 0 asynchronously; after release, FETCH with `irWrite=1`.

Source files
------------

// File: rtl/controller_fsm_pkg.sv
// Shared types for the multi-cycle RISC-V controller: opcodes,
// ALU ops, datapath select encodings and controller states.
package pa_riscv;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_R_ALU  = 7'b0110011,
    OP_I_ALU  = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } ty_OPERAND;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } ty_ALU_OP;

  typedef enum logic [1:0] {
    RESULT_ALU        = 2'b00,
    RESULT_DATAMEMORY = 2'b01,
    RESULT_PCPLUS4    = 2'b10
  } ty_RESULT_SRC;

  typedef enum logic [1:0] {
    SRCA_PC              = 2'b00,
    SRCA_OTHER           = 2'b01,
    SRCA_REG_READ_DATA_1 = 2'b10
  } ty_ALU_SRC_A;

  typedef enum logic [1:0] {
    SRCB_REG_READ_DATA_2     = 2'b00,
    SRCB_IMMEDIATE_EXTENDED  = 2'b01,
    SRCB_FOUR                = 2'b10
  } ty_ALU_SRC_B;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } ty_IMM_SRC;

  typedef enum logic [1:0] {
    ALUDEC_ADD   = 2'b00,
    ALUDEC_SUB   = 2'b01,
    ALUDEC_FUNCT = 2'b10
  } ty_ALU_DEC;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_JAL
  } ty_STATE;

endpackage

// File: rtl/controller_fsm_alu_decoder.sv
// ALU control decode: fixed ADD/SUB or funct-driven operation.
// I-type ops ignore funct7b5 (opcode[5] distinguishes R from I).
module alu_decoder
  import pa_riscv::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_opcode5,
  output logic [3:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    unique case (i_alu_op)
      ALUDEC_ADD: o_alu_control = ALU_ADD;
      ALUDEC_SUB: o_alu_control = ALU_SUB;
      default:
        o_alu_control = {i_opcode5 & i_funct7b5, i_funct3};
    endcase
  end

endmodule

// File: rtl/controller_fsm.sv
// Multi-cycle RISC-V main controller (Moore FSM).
// Define RISCV_BNE_EN to add BNE and reject other branch funct3.
module controller_fsm
  import pa_riscv::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_pcWrite,
  output logic       o_adrSrc,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_regWrite,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_immSrc,
  output logic [3:0] o_aluControl,
  output logic       o_illegal
);

  ty_STATE   state;
  ty_STATE   state_next;
  ty_ALU_DEC alu_op;
  logic      pc_write;
  logic      mem_write;
  logic      ir_write;
  logic      reg_write;
  logic      illegal;
  logic      br_taken;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_FETCH;
    else       state <= state_next;
  end

`ifdef RISCV_BNE_EN
  assign br_taken = i_funct3[0] ? ~i_zero : i_zero;
`else
  assign br_taken = i_zero;
`endif

  always_comb begin
    state_next  = state;
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    o_adrSrc    = 1'b0;
    o_resultSrc = RESULT_ALU;
    o_aluSrcA   = SRCA_PC;
    o_aluSrcB   = SRCB_REG_READ_DATA_2;
    alu_op      = ALUDEC_ADD;
    unique case (state)
      S_FETCH: begin
        ir_write    = 1'b1;
        pc_write    = 1'b1;
        o_aluSrcB   = SRCB_FOUR;
        o_resultSrc = RESULT_PCPLUS4;
        state_next  = S_DECODE;
      end
      S_DECODE: begin
        o_aluSrcA  = SRCA_OTHER;
        o_aluSrcB  = SRCB_IMMEDIATE_EXTENDED;
        state_next = S_FETCH;
        case (i_opcode)
          OP_LOAD,
          OP_STORE:  state_next = S_MEMADR;
          OP_R_ALU:  state_next = S_EXECUTER;
          OP_I_ALU:  state_next = S_EXECUTEI;
          OP_JAL:    state_next = S_JAL;
`ifdef RISCV_BNE_EN
          OP_BRANCH:
            if (i_funct3[2:1] == 2'b00) state_next = S_BRANCH;
            else                        illegal    = 1'b1;
`else
          OP_BRANCH: state_next = S_BRANCH;
`endif
          default:   illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        o_aluSrcA  = SRCA_REG_READ_DATA_1;
        o_aluSrcB  = SRCB_IMMEDIATE_EXTENDED;
        state_next = (i_opcode == OP_STORE) ? S_MEMWRITE
                                            : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_adrSrc   = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_resultSrc = RESULT_DATAMEMORY;
        reg_write   = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        o_adrSrc   = 1'b1;
        mem_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECUTER: begin
        o_aluSrcA  = SRCA_REG_READ_DATA_1;
        o_aluSrcB  = SRCB_REG_READ_DATA_2;
        alu_op     = ALUDEC_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        o_aluSrcA  = SRCA_REG_READ_DATA_1;
        o_aluSrcB  = SRCB_IMMEDIATE_EXTENDED;
        alu_op     = ALUDEC_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        o_aluSrcA  = SRCA_REG_READ_DATA_1;
        o_aluSrcB  = SRCB_REG_READ_DATA_2;
        alu_op     = ALUDEC_SUB;
        pc_write   = br_taken;
        state_next = S_FETCH;
      end
      S_JAL: begin
        o_aluSrcA  = SRCA_OTHER;
        o_aluSrcB  = SRCB_FOUR;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    o_immSrc = IMM_I;
    unique case (1'b1)
      i_opcode == OP_STORE:  o_immSrc = IMM_S;
      i_opcode == OP_BRANCH: o_immSrc = IMM_B;
      i_opcode == OP_JAL:    o_immSrc = IMM_J;
      default:               o_immSrc = IMM_I;
    endcase
  end

  // strobes must be quiet for the whole time reset is held
  assign o_pcWrite  = pc_write  & ~i_rst;
  assign o_memWrite = mem_write & ~i_rst;
  assign o_irWrite  = ir_write  & ~i_rst;
  assign o_regWrite = reg_write & ~i_rst;
  assign o_illegal  = illegal   & ~i_rst;

  alu_decoder u_alu_dec (
    .i_alu_op      (alu_op),
    .i_funct3      (i_funct3),
    .i_funct7b5    (i_funct7b5),
    .i_opcode5     (i_opcode[5]),
    .o_alu_control (o_aluControl)
  );

endmodule
